display_sequencer: RTL and testbench
====================================

# display_sequencer

Power-up and run-time sequencer for the pixel pipeline, clocked by the pixel clock. Holds `display_timings` in reset until the `display_clocks` lock has been stable for a set time, then blanks output for a set number of frames before enabling colour. Switches the pixel source only on frame boundaries, inserting one blank frame per switch. Drives the timing-generator reset, the colour/DE output gate and the source select for the top level.

## Interface

- `LOCK_CYCLES`, 1024: pixel clocks that the synchronised lock must stay high before the timings are released; range ≥1.
- `BLANK_FRAMES`, 2: `i_frame` pulses with output gated off after release; range 0–255.
- `WD_CYCLES`, 1000000: frame watchdog timeout in pixel clocks; used only with `FRAME_WATCHDOG_EN`.
- `i_pixclk`  in  1  pixel clock; the only clock.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_locked`  in  1  clock-lock from `display_clocks`; asynchronous to `i_pixclk`.
- `i_frame`  in  1  one-cycle frame-start pulse from `display_timings`.
- `i_src_req`  in  2  requested pixel source.
- `o_timing_rst`  out  1  reset to `display_timings`; high = held in reset.
- `o_out_en`  out  1  gate for DE and colour outputs; high = drive pixels.
- `o_src`  out  2  active pixel source select.
- `o_state`  out  3  current state encoding, for status/debug.
- `o_fault`  out  1  sticky frame-watchdog fault.

## Operation

- `i_locked` passes through a 2-flop synchroniser to give `locked_s`. No other logic samples `i_locked` directly.
- All outputs are registered.
- Reset values:
  - state = WAIT_LOCK
  - `o_timing_rst` = 1, `o_out_en` = 0
  - `o_src` = 0, `o_state` = 0, `o_fault` = 0
  - all counters = 0
- State encodings: WAIT_LOCK = 0, SETTLE = 1, BLANK = 2, ACTIVE = 3, SWITCH = 4.
- WAIT_LOCK: `o_timing_rst` = 1, `o_out_en` = 0. If `locked_s`, go to SETTLE and clear the cycle counter.
- SETTLE: `o_timing_rst` = 1. The cycle counter (`$clog2(LOCK_CYCLES)` bits) increments every cycle.
  - If `!locked_s`, go to WAIT_LOCK.
  - Else if counter == `LOCK_CYCLES-1`, go to BLANK (or to ACTIVE if `BLANK_FRAMES` == 0) and clear the 8-bit frame counter.
- BLANK: `o_timing_rst` = 0, `o_out_en` = 0. Each `i_frame` increments the frame counter. On the `i_frame` that makes it reach `BLANK_FRAMES`, go to ACTIVE.
- ACTIVE: `o_out_en` = 1. On `i_frame` with `i_src_req` ≠ `o_src`: load `o_src` ← `i_src_req` and go to SWITCH. A request change without `i_frame` has no effect.
- SWITCH: `o_out_en` = 0. On `i_frame`:
  - if `i_src_req` ≠ `o_src`, reload `o_src` and stay in SWITCH;
  - otherwise go to ACTIVE.
- Lock loss: `!locked_s` in SETTLE, BLANK, ACTIVE or SWITCH goes to WAIT_LOCK on the next edge. This has priority over every other transition. `o_src` is retained.
- `i_rst` mid-operation returns all state to reset values asynchronously.

## Timing

- Release: `i_locked` first sampled high at edge 1 → `locked_s` at edge 2 → SETTLE at edge 3 → `o_timing_rst` falls at edge `LOCK_CYCLES+3`.
- Output enable: BLANK→ACTIVE occurs on the edge sampling the qualifying `i_frame`. `o_out_en` is high from that edge.
- Lock drop: `i_locked` falls before edge 1 → `locked_s` low at edge 2 → `o_timing_rst` = 1 and `o_out_en` = 0 from edge 3.
- Source switch: `o_src` changes and `o_out_en` falls on the same edge, the one sampling `i_frame`. `o_out_en` rises on the edge sampling the next `i_frame`. Exactly one frame is blanked per switch.
- `i_frame` in WAIT_LOCK or SETTLE is ignored.
- `o_state` reflects the registered state with no extra latency.

## Configuration

- `FRAME_WATCHDOG_EN` defined:
  - A cycle counter runs in BLANK, ACTIVE and SWITCH. It clears on `i_frame` and on entry to BLANK.
  - When it reaches `WD_CYCLES-1` without an `i_frame`, `o_fault` is set and the state goes to WAIT_LOCK, re-running the full sequence.
  - `o_fault` stays high until `i_rst`.
  - Lock loss on the same edge takes priority but does not set `o_fault`.
- `FRAME_WATCHDOG_EN` undefined: no watchdog logic is built, `o_fault` is tied 0 and `WD_CYCLES` is unused.

## Test plan

All scenarios use `LOCK_CYCLES`=16, `BLANK_FRAMES`=2, `WD_CYCLES`=1000, with frame pulses every 200 cycles.

- Reset then `i_locked`=1 → `o_timing_rst` falls at edge 19. `o_out_en` rises on the edge of the 2nd `i_frame` after release. `o_state` sequence is 0,1,2,3.
- `i_locked` drops for 3 cycles at cycle 10 of SETTLE → return to WAIT_LOCK and the counter restarts. `o_timing_rst` stays 1 throughout.
- In ACTIVE, `i_src_req`=2 set mid-frame → `o_src` becomes 2 and `o_out_en`=0 at the next `i_frame`. `o_out_en`=1 one frame later.
- In ACTIVE, `i_locked`=0 → `o_timing_rst`=1 and `o_out_en`=0 two edges later. `o_src` is unchanged. Relock repeats the full sequence.
- `BLANK_FRAMES`=0 → ACTIVE directly at edge 19, with no frames blanked.
- `FRAME_WATCHDOG_EN` defined, `i_frame` stopped in ACTIVE → `o_fault`=1 and WAIT_LOCK after 1000 cycles. `o_fault` holds through the re-sequence and clears only on `i_rst`.

Source files
------------

// File: rtl/display_sequencer.sv
// display_sequencer: lock-qualified power-up and frame-aligned source switching.
// Defining FRAME_WATCHDOG_EN adds a sticky frame watchdog that forces a re-sequence.
module display_sequencer #(
    parameter int unsigned LOCK_CYCLES  = 1024,
    parameter int unsigned BLANK_FRAMES = 2,
    parameter int unsigned WD_CYCLES    = 1000000
) (
    input  logic       i_pixclk,
    input  logic       i_rst,
    input  logic       i_locked,
    input  logic       i_frame,
    input  logic [1:0] i_src_req,
    output logic       o_timing_rst,
    output logic       o_out_en,
    output logic [1:0] o_src,
    output logic [2:0] o_state,
    output logic       o_fault
);
    localparam int unsigned CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(LOCK_CYCLES - 1);
    localparam logic [7:0] BF = 8'(BLANK_FRAMES);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        SETTLE    = 3'd1,
        BLANK     = 3'd2,
        ACTIVE    = 3'd3,
        SWITCH    = 3'd4
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          lock_m;
    logic          locked_s;
    logic [CW-1:0] cyc_q;
    logic [CW-1:0] cyc_d;
    logic [7:0]    frm_q;
    logic [7:0]    frm_d;
    logic [1:0]    src_d;
    logic          wd_trip;

`ifdef FRAME_WATCHDOG_EN
    localparam int unsigned WW = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
    localparam logic [WW-1:0] WD_LAST = WW'(WD_CYCLES - 1);

    logic [WW-1:0] wd_q;
    logic          wd_run;
    logic          fault_q;

    assign wd_run  = (state_q == BLANK) || (state_q == ACTIVE) ||
                     (state_q == SWITCH);
    assign wd_trip = wd_run && !i_frame && (wd_q == WD_LAST);

    // Held at zero outside the running states, which also clears it on BLANK entry.
    always_ff @(posedge i_pixclk or posedge i_rst) begin
        if (i_rst) begin
            wd_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            if (!wd_run || i_frame || !locked_s || wd_trip) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + 1'b1;
            end
            if (wd_trip && locked_s) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign o_fault = fault_q;
`else
    assign wd_trip = 1'b0;
    assign o_fault = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cyc_d   = '0;
        frm_d   = frm_q;
        src_d   = o_src;
        unique case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == CYC_LAST) begin
                    state_d = (BF == 8'd0) ? ACTIVE : BLANK;
                    frm_d   = '0;
                end
            end
            BLANK: begin
                if (i_frame) begin
                    frm_d = frm_q + 8'd1;
                    if (frm_d == BF) begin
                        state_d = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                if (i_frame && (i_src_req != o_src)) begin
                    src_d   = i_src_req;
                    state_d = SWITCH;
                end
            end
            SWITCH: begin
                if (i_frame) begin
                    if (i_src_req != o_src) begin
                        src_d = i_src_req;
                    end else begin
                        state_d = ACTIVE;
                    end
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
        if (wd_trip) begin
            state_d = WAIT_LOCK;
        end
        // Lock loss overrides everything but keeps the selected source.
        if (!locked_s && (state_q != WAIT_LOCK)) begin
            state_d = WAIT_LOCK;
            cyc_d   = '0;
        end
    end

    always_ff @(posedge i_pixclk or posedge i_rst) begin
        if (i_rst) begin
            lock_m       <= 1'b0;
            locked_s     <= 1'b0;
            state_q      <= WAIT_LOCK;
            cyc_q        <= '0;
            frm_q        <= '0;
            o_src        <= 2'd0;
            o_timing_rst <= 1'b1;
            o_out_en     <= 1'b0;
        end else begin
            lock_m       <= i_locked;
            locked_s     <= lock_m;
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            frm_q        <= frm_d;
            o_src        <= src_d;
            o_timing_rst <= (state_d == WAIT_LOCK) || (state_d == SETTLE);
            o_out_en     <= (state_d == ACTIVE);
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Bench for display_sequencer: random stimulus, countdown-style reference model,
// scoreboard queues per DUT (BLANK_FRAMES = 2 and BLANK_FRAMES = 0).
module tb_display_sequencer;
    localparam int LOCK = 16;
    localparam int WD   = 1000;

    typedef struct packed {
        logic       trst;
        logic       oen;
        logic [1:0] src;
        logic [2:0] st;
        logic       fault;
    } obs_t;

    // phase: 0 wait lock, 1 settle, 2 blank, 3 active, 4 switch
    typedef struct {
        int phase;
        bit sync1;
        bit sync2;
        int settle_left;
        int blank_left;
        int wd_left;
        int src;
        bit fault;
    } mdl_t;

    logic       clk;
    logic       rst;
    logic       locked;
    logic       frame;
    logic [1:0] req;

    logic       trst2, oen2, fault2;
    logic [1:0] src2;
    logic [2:0] st2;
    logic       trst0, oen0, fault0;
    logic [1:0] src0;
    logic [2:0] st0;

    display_sequencer #(
        .LOCK_CYCLES (LOCK),
        .BLANK_FRAMES(2),
        .WD_CYCLES   (WD)
    ) u_bf2 (
        .i_pixclk    (clk),
        .i_rst       (rst),
        .i_locked    (locked),
        .i_frame     (frame),
        .i_src_req   (req),
        .o_timing_rst(trst2),
        .o_out_en    (oen2),
        .o_src       (src2),
        .o_state     (st2),
        .o_fault     (fault2)
    );

    display_sequencer #(
        .LOCK_CYCLES (LOCK),
        .BLANK_FRAMES(0),
        .WD_CYCLES   (WD)
    ) u_bf0 (
        .i_pixclk    (clk),
        .i_rst       (rst),
        .i_locked    (locked),
        .i_frame     (frame),
        .i_src_req   (req),
        .o_timing_rst(trst0),
        .o_out_en    (oen0),
        .o_src       (src0),
        .o_state     (st0),
        .o_fault     (fault0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk;
    int   n_pass;
    int   cyc;
    obs_t q2[$];
    obs_t q0[$];
    mdl_t m2;
    mdl_t m0;
    bit   frames_on;
    int   gap;

    function automatic mdl_t mreset();
        mdl_t n;
        n.phase       = 0;
        n.sync1       = 0;
        n.sync2       = 0;
        n.settle_left = 0;
        n.blank_left  = 0;
        n.wd_left     = 0;
        n.src         = 0;
        n.fault       = 0;
        return n;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit r, bit lk, bit fr, int rq, int bf);
        mdl_t n;
        bit   ls;
        if (r) return mreset();
        n       = m;
        ls      = m.sync2;
        n.sync2 = m.sync1;
        n.sync1 = lk;
        if (m.phase != 0 && !ls) begin
            n.phase = 0;
            return n;
        end
        case (m.phase)
            0: if (ls) begin
                n.phase       = 1;
                n.settle_left = LOCK;
            end
            1: if (m.settle_left == 1) begin
                n.phase      = (bf == 0) ? 3 : 2;
                n.blank_left = bf;
                n.wd_left    = WD;
            end else begin
                n.settle_left = m.settle_left - 1;
            end
            2: if (fr) begin
                if (m.blank_left == 1) n.phase = 3;
                else n.blank_left = m.blank_left - 1;
            end
            3: if (fr && rq != m.src) begin
                n.src   = rq;
                n.phase = 4;
            end
            4: if (fr) begin
                if (rq != m.src) n.src = rq;
                else n.phase = 3;
            end
            default: ;
        endcase
`ifdef FRAME_WATCHDOG_EN
        if (m.phase >= 2) begin
            if (fr) begin
                n.wd_left = WD;
            end else if (m.wd_left == 1) begin
                n.fault = 1;
                n.phase = 0;
            end else begin
                n.wd_left = m.wd_left - 1;
            end
        end
`endif
        return n;
    endfunction

    function automatic obs_t expect_of(mdl_t m);
        obs_t o;
        o.trst  = (m.phase < 2);
        o.oen   = (m.phase == 3);
        o.src   = 2'(m.src);
        o.st    = 3'(m.phase);
        o.fault = m.fault;
        return o;
    endfunction

    task automatic check(input string nm, input obs_t got, input obs_t want);
        n_chk++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d got trst=%b oen=%b src=%0d st=%0d fault=%b want trst=%b oen=%b src=%0d st=%0d fault=%b",
                     nm, cyc, got.trst, got.oen, got.src, got.st, got.fault,
                     want.trst, want.oen, want.src, want.st, want.fault);
        end
    endtask

    task automatic check_val(input string nm, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s got=%0d want=%0d", nm, got, want);
    endtask

    task automatic step(input bit r, input bit lk);
        bit fr;
        fr = frames_on && (gap == 0);
        if (gap == 0) gap = $urandom_range(80, 30);
        else gap--;
        @(negedge clk);
        if ($urandom_range(24, 0) == 0) req = 2'($urandom_range(3, 0));
        rst    = r;
        locked = lk;
        frame  = fr;
        m2 = mstep(m2, r, lk, fr, int'(req), 2);
        m0 = mstep(m0, r, lk, fr, int'(req), 0);
        q2.push_back(expect_of(m2));
        q0.push_back(expect_of(m0));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q2.size() > 0) check("bf2", {trst2, oen2, src2, st2, fault2}, q2.pop_front());
            if (q0.size() > 0) check("bf0", {trst0, oen0, src0, st0, fault0}, q0.pop_front());
        end
    end

    initial begin
        int  rel;
        int  drop;
        bit  exp_fault;
        n_chk     = 0;
        n_pass    = 0;
        cyc       = 0;
        rst       = 1'b1;
        locked    = 1'b0;
        frame     = 1'b0;
        req       = 2'd0;
        m2        = mreset();
        m0        = mreset();
        frames_on = 1'b1;
        gap       = 7;
`ifdef FRAME_WATCHDOG_EN
        exp_fault = 1'b1;
`else
        exp_fault = 1'b0;
`endif

        repeat (4) step(1, 0);

        // Release edge: locked driven high before edge 1.
        rel = 0;
        for (int e = 1; e <= 60 && rel == 0; e++) begin
            step(0, 1);
            @(posedge clk);
            #2;
            if (!trst2) begin
                rel = e;
                check_val("bf2_state_at_release", int'(st2), 2);
                check_val("bf0_state_at_release", int'(st0), 3);
            end
        end
        check_val("release_edge", rel, LOCK + 3);

        repeat (800) step(0, 1);

        // Lock drop at cycle 10 of SETTLE.
        repeat (2) step(1, 0);
        repeat (13) step(0, 1);
        repeat (3) step(0, 0);
        repeat (300) step(0, 1);

        // Random lock glitches while running.
        drop = 0;
        for (int i = 0; i < 3000; i++) begin
            if (drop == 0 && $urandom_range(399, 0) == 0) drop = $urandom_range(6, 1);
            if (drop > 0) begin
                drop--;
                step(0, 0);
            end else begin
                step(0, 1);
            end
        end
        repeat (200) step(0, 1);

        // Frames stop in ACTIVE.
        frames_on = 1'b0;
        repeat (1100) step(0, 1);
        #2;
        check_val("fault_after_stop", int'(fault2), int'(exp_fault));
        frames_on = 1'b1;
        repeat (500) step(0, 1);
        #2;
        check_val("fault_held", int'(fault2), int'(exp_fault));

        // Asynchronous reset mid-operation clears the sticky fault.
        repeat (2) step(1, 1);
        #2;
        check_val("fault_cleared", int'(fault2), 0);
        repeat (200) step(0, 1);

        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
